mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage. Each 1/2/4-byte request is serialized into consecutive byte accesses, read bytes are assembled little-endian into a 32-bit word, and completion is signalled with a one-cycle done pulse. It sits between the pipeline stages and the external RAM; the MEM stage's `mem_stall` is driven by the inverse of this block's done.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states, port owner,
// request length codes and common constants.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    typedef enum logic {
        OwnIf,
        OwnMem
    } owner_e;

    // mem_len_i holds byte count minus one
    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd3;

    localparam logic        True  = 1'b1;
    localparam logic        False = 1'b0;
    localparam logic [31:0] Zero  = 32'h0;

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 1/2/4-byte requests and assembling read bytes little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_r_req_i,
    input  logic              mem_w_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_w_data_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_data_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    state_e            state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        n_q;
    logic [2:0]        cnt_q;
    logic [31:0]       buf_q;

    logic [2:0]        cnt_nx;
    logic [1:0]        lane;
    logic [31:0]       buf_merged;
    logic [ADDR_W-1:0] next_a;
    logic [7:0]        wr_byte;

    always_comb begin
        cnt_nx = cnt_q + 3'd1;
        // cnt == 4 wraps to lane 3 through the 2-bit subtraction
        lane   = 2'(cnt_q[1:0] - 2'd1);
        next_a = base_q + ADDR_W'(cnt_nx);
        wr_byte = mem_w_data_i[{cnt_nx[1:0], 3'b000} +: 8];
        buf_merged = buf_q;
        buf_merged[{lane, 3'b000} +: 8] = ram_din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= OwnIf;
            base_q     <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            buf_q      <= Zero;
            if_done_o  <= False;
            if_data_o  <= Zero;
            mem_done_o <= False;
            mem_data_o <= Zero;
            ram_dout_o <= '0;
            ram_a_o    <= '0;
            ram_wr_o   <= False;
        end else begin
            if_done_o  <= False;
            mem_done_o <= False;
            ram_wr_o   <= False;
            ram_a_o    <= '0;
            ram_dout_o <= '0;
            unique case (state_q)
                StIdle: begin
                    if (mem_r_req_i || mem_w_req_i) begin
                        owner_q <= OwnMem;
                        base_q  <= mem_addr_i;
                        n_q     <= 3'(mem_len_i) + 3'd1;
                        cnt_q   <= '0;
                        buf_q   <= Zero;
                        ram_a_o <= mem_addr_i;
                        if (mem_w_req_i) begin
                            state_q    <= StWrite;
                            ram_wr_o   <= True;
                            ram_dout_o <= mem_w_data_i[7:0];
                        end else begin
                            state_q <= StRead;
                        end
                    end else if (if_req_i && !if_flush_i) begin
                        owner_q <= OwnIf;
                        base_q  <= if_addr_i;
                        n_q     <= 3'(LenWord) + 3'd1;
                        cnt_q   <= '0;
                        buf_q   <= Zero;
                        ram_a_o <= if_addr_i;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (owner_q == OwnIf && if_flush_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q != 3'd0) buf_q <= buf_merged;
                        if (cnt_q == n_q) begin
                            state_q <= StDone;
                            if (owner_q == OwnIf) begin
                                if_done_o <= True;
                                if_data_o <= buf_merged;
                            end else begin
                                mem_done_o <= True;
                                mem_data_o <= buf_merged;
                            end
                        end else begin
                            cnt_q <= cnt_nx;
                            if (cnt_nx != n_q) ram_a_o <= next_a;
                        end
                    end
                end
                StWrite: begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_q    <= StDone;
                        mem_done_o <= True;
                        mem_data_o <= buf_q;
                    end else begin
                        cnt_q      <= cnt_nx;
                        ram_wr_o   <= True;
                        ram_a_o    <= next_a;
                        ram_dout_o <= wr_byte;
                    end
                end
                StDone: begin
                    // requests are deliberately not sampled here
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, scoreboard of expected done results
// and cycle-exact checks of the RAM port and done timing.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_r_req, mem_w_req;
    logic [31:0] if_addr, mem_addr, mem_w_data;
    logic [1:0]  mem_len;
    logic        if_done, mem_done, ram_wr;
    logic [31:0] if_data, mem_data, ram_a;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0]  ram [0:4095];
    logic        load;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_flush_i   (if_flush),
        .if_done_o    (if_done),
        .if_data_o    (if_data),
        .mem_r_req_i  (mem_r_req),
        .mem_w_req_i  (mem_w_req),
        .mem_addr_i   (mem_addr),
        .mem_len_i    (mem_len),
        .mem_w_data_i (mem_w_data),
        .mem_done_o   (mem_done),
        .mem_data_o   (mem_data),
        .ram_din_i    (ram_din),
        .ram_dout_o   (ram_dout),
        .ram_a_o      (ram_a),
        .ram_wr_o     (ram_wr)
    );

    // RAM model: synchronous read (one-cycle latency), synchronous write
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
            ram[12'h200] <= 8'hFE; ram[12'h201] <= 8'hFF;
            ram[12'h202] <= 8'h12; ram[12'h203] <= 8'h34;
            ram[12'h400] <= 8'h11; ram[12'h401] <= 8'h22;
            ram[12'h402] <= 8'h33; ram[12'h403] <= 8'h44;
        end else if (ram_wr) begin
            ram[ram_a[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (if_done || mem_done)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {30'b0, if_done, mem_done}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("done_owner", {31'b0, if_done}, {31'b0, e.is_if});
                check("done_data", if_done ? if_data : mem_data, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; mem_r_req = 1'b0; mem_w_req = 1'b0;
        if_addr = '0; mem_addr = '0; mem_w_data = '0; mem_len = '0;
        repeat (3) @(negedge clk);
        load = 1'b0;
        check("rst_if_done", {31'b0, if_done}, 32'h0);
        check("rst_mem_done", {31'b0, mem_done}, 32'h0);
        check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
        check("rst_ram_a", ram_a, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_data", mem_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // IF word fetch from 0x100
        if_addr = 32'h100; if_req = 1'b1;
        sb.push_back('{1'b1, 32'h00100513});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) check("fetch_ram_a", ram_a, 32'h100 + 32'(k - 1));
            check("fetch_done_time", {31'b0, if_done}, {31'b0, k == 6});
        end
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_data_held", if_data, 32'h00100513);

        // SB to 0x30000; request held through the done cycle
        mem_addr = 32'h30000; mem_w_data = 32'h123456AB; mem_len = 2'd0; mem_w_req = 1'b1;
        sb.push_back('{1'b0, 32'h0});
        @(negedge clk);
        check("sb_wr", {31'b0, ram_wr}, 32'h1);
        check("sb_addr", ram_a, 32'h30000);
        check("sb_dout", {24'b0, ram_dout}, 32'hAB);
        @(negedge clk);
        check("sb_done", {31'b0, mem_done}, 32'h1);
        check("sb_wr_off", {31'b0, ram_wr}, 32'h0);
        @(negedge clk);
        mem_w_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("no_second_write", {31'b0, ram_wr}, 32'h0);
            @(negedge clk);
        end
        check("sb_ram_byte", {24'b0, ram[12'h000]}, 32'hAB);
        check("sb_ram_next", {24'b0, ram[12'h001]}, 32'h00);

        // Simultaneous LH from 0x200 and IF fetch from 0x100: MEM wins
        mem_addr = 32'h200; mem_len = 2'd1; mem_r_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        sb.push_back('{1'b0, 32'h0000FFFE});
        sb.push_back('{1'b1, 32'h00100513});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 2) check("lh_ram_a", ram_a, 32'h200 + 32'(k - 1));
            if (k == 6) check("if_after_mem_a", ram_a, 32'h100);
            check("lh_done_time", {31'b0, mem_done}, {31'b0, k == 4});
            check("if2_done_time", {31'b0, if_done}, {31'b0, k == 11});
            if (k == 4) mem_r_req = 1'b0;
        end
        if_req = 1'b0;
        @(negedge clk);
        check("lh_data_held", mem_data, 32'h0000FFFE);

        // Fetch from 0x400 flushed at t+3, then a clean fetch from 0x200
        if_addr = 32'h400; if_req = 1'b1;
        repeat (3) @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        check("flush_ram_a", ram_a, 32'h0);
        repeat (6) @(negedge clk);
        check("flush_no_data", if_data, 32'h00100513);
        if_addr = 32'h200; if_req = 1'b1;
        sb.push_back('{1'b1, 32'h3412FFFE});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("refetch_done_time", {31'b0, if_done}, {31'b0, k == 6});
        end
        if_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a 4-byte store
        mem_addr = 32'h500; mem_w_data = 32'hDEADBEEF; mem_len = 2'd3; mem_w_req = 1'b1;
        @(negedge clk);
        check("sw_wr0", {31'b0, ram_wr}, 32'h1);
        check("sw_dout0", {24'b0, ram_dout}, 32'hEF);
        @(negedge clk);
        check("sw_addr1", ram_a, 32'h501);
        check("sw_dout1", {24'b0, ram_dout}, 32'hBE);
        rst = 1'b1; mem_w_req = 1'b0;
        @(negedge clk);
        check("rst_mid_wr", {31'b0, ram_wr}, 32'h0);
        check("rst_mid_a", ram_a, 32'h0);
        check("rst_mid_dout", {24'b0, ram_dout}, 32'h0);
        check("rst_mid_done", {30'b0, if_done, mem_done}, 32'h0);
        check("rst_mid_data", if_data | mem_data, 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("sw_ram_500", {24'b0, ram[12'h500]}, 32'hEF);
        check("sw_ram_501", {24'b0, ram[12'h501]}, 32'hBE);
        check("sw_ram_502", {24'b0, ram[12'h502]}, 32'h00);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
